// File: rtl/gray_deserializer_fb.sv
// gray_deserializer_fb
// Recovers a 10-bit word from a serial feedback stream in which slot k is
// transmitted 2^(9-k) times per 1024-cycle frame (binary-reflected "ruler"
// ordering). The slot of each cycle is the trailing-zero count of cnt+1;
// cnt=1023 is the idle slot, where the completed frame is published.
//
// Ports
//   clk_ext      : sole clock, rising edge
//   rst_ext      : synchronous, active-high reset (highest priority)
//   en           : advance enable; low freezes all state
//   frame_sync   : single-cycle resync pulse, restarts the frame at cnt=0
//   ser_in       : serial bitstream
//   word_out     : recovered word, bit k = value carried in slot k
//   weight_out   : number of ones sampled over the last completed frame
//   frame_valid  : one-cycle pulse when the outputs update
//   frame_err    : last completed frame saw a slot with differing samples
module gray_deserializer_fb #(
  parameter int ALIGN_DLY = 0
) (
  input  logic       clk_ext,
  input  logic       rst_ext,
  input  logic       en,
  input  logic       frame_sync,
  input  logic       ser_in,
  output logic [9:0] word_out,
  output logic [9:0] weight_out,
  output logic       frame_valid,
  output logic       frame_err
);

  logic       s;

  logic [9:0] cnt_q, cnt_d;
  logic [9:0] shadow_q, shadow_d;
  logic [9:0] seen_q, seen_d;
  logic       err_q, err_d;
  logic [9:0] acc_q, acc_d;
  logic [9:0] word_q, word_d;
  logic [9:0] weight_q, weight_d;
  logic       fv_q, fv_d;
  logic       ferr_q, ferr_d;

  logic [9:0] cnt_inc;
  logic [9:0] slot_oh;
  logic       idle;

  // Alignment delay line; it only moves on enabled cycles so that an en gap
  // does not slip the stream against the slot counter.
  generate
    if (ALIGN_DLY == 0) begin : g_nodly
      assign s = ser_in;
    end else begin : g_dly
      logic [ALIGN_DLY-1:0] dly_q, dly_d;

      always_comb begin
        dly_d = dly_q;
        if (en) dly_d = (dly_q << 1) | ALIGN_DLY'(ser_in);
      end

      always_ff @(posedge clk_ext) begin
        if (rst_ext) dly_q <= '0;
        else         dly_q <= dly_d;
      end

      assign s = dly_q[ALIGN_DLY-1];
    end
  endgenerate

  // Lowest set bit of cnt+1 as a one-hot slot select. At cnt=1023 the
  // 10-bit increment wraps to zero, so no slot is selected: the idle slot.
  assign cnt_inc = cnt_q + 10'd1;
  assign slot_oh = cnt_inc & (~cnt_inc + 10'd1);
  assign idle    = (cnt_q == 10'h3FF);

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    seen_d   = seen_q;
    err_d    = err_q;
    acc_d    = acc_q;
    word_d   = word_q;
    weight_d = weight_q;
    fv_d     = 1'b0;
    ferr_d   = ferr_q;

    if (frame_sync) begin
      // Resync wins over the idle slot: the partial frame is dropped and the
      // published outputs are left untouched.
      cnt_d  = '0;
      seen_d = '0;
      err_d  = 1'b0;
      acc_d  = '0;
    end else if (en) begin
      cnt_d = cnt_inc;
      if (idle) begin
        word_d   = shadow_q;
        weight_d = acc_q;
        ferr_d   = err_q;
        fv_d     = 1'b1;
        seen_d   = '0;
        err_d    = 1'b0;
        acc_d    = '0;
      end else begin
        if (|(seen_q & slot_oh & (shadow_q ^ {10{s}}))) err_d = 1'b1;
        shadow_d = (shadow_q & ~slot_oh) | (slot_oh & {10{s}});
        seen_d   = seen_q | slot_oh;
        acc_d    = acc_q + {9'd0, s};
      end
    end
  end

  always_ff @(posedge clk_ext) begin
    if (rst_ext) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      seen_q   <= '0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      word_q   <= '0;
      weight_q <= '0;
      fv_q     <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      word_q   <= word_d;
      weight_q <= weight_d;
      fv_q     <= fv_d;
      ferr_q   <= ferr_d;
    end
  end

  assign word_out    = word_q;
  assign weight_out  = weight_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_gray_deserializer_fb.sv
module tb_gray_deserializer_fb;

  logic       clk_ext = 1'b0;
  logic       rst_ext = 1'b0;
  logic       en = 1'b0;
  logic       frame_sync = 1'b0;
  logic       ser0 = 1'b0;
  logic       ser2 = 1'b0;
  logic [9:0] word0, wt0, word2, wt2;
  logic       fv0, err0, fv2, err2;

  always #5 clk_ext = ~clk_ext;

  gray_deserializer_fb #(.ALIGN_DLY(0)) u_dut0 (
    .clk_ext(clk_ext), .rst_ext(rst_ext), .en(en), .frame_sync(frame_sync),
    .ser_in(ser0), .word_out(word0), .weight_out(wt0),
    .frame_valid(fv0), .frame_err(err0)
  );

  gray_deserializer_fb #(.ALIGN_DLY(2)) u_dut2 (
    .clk_ext(clk_ext), .rst_ext(rst_ext), .en(en), .frame_sync(frame_sync),
    .ser_in(ser2), .word_out(word2), .weight_out(wt2),
    .frame_valid(fv2), .frame_err(err2)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: per frame, every sample is recorded against the frame
  // position it was taken at; the frame result is computed from that record.
  int         m_cnt = 0;
  bit         rec  [2][1024];
  bit         recv [2][1024];
  bit         hq2 [$];
  logic [9:0] e_word [2];
  logic [9:0] e_wt   [2];
  logic       e_fv   [2];
  logic       e_err  [2];

  function automatic int slot_of(int c);
    int x = c + 1;
    int k = 0;
    while (k < 10 && (x % 2) == 0) begin
      x = x / 2;
      k++;
    end
    return k;
  endfunction

  function automatic bit pat_bit(int c, logic [9:0] p);
    int k = slot_of(c % 1024);
    if (k < 10) return p[k];
    return 1'b0;
  endfunction

  task automatic clear_rec(int i);
    for (int c = 0; c < 1024; c++) recv[i][c] = 1'b0;
  endtask

  task automatic close_frame(int i);
    logic [9:0] w = e_word[i];
    bit first [10];
    bit have  [10];
    bit er = 1'b0;
    int ones = 0;
    for (int k = 0; k < 10; k++) have[k] = 1'b0;
    for (int c = 0; c < 1023; c++) begin
      if (recv[i][c]) begin
        int k = slot_of(c);
        if (have[k] && rec[i][c] != first[k]) er = 1'b1;
        if (!have[k]) begin
          first[k] = rec[i][c];
          have[k] = 1'b1;
        end
        w[k] = rec[i][c];
        ones += int'(rec[i][c]);
      end
    end
    e_word[i] = w;
    e_wt[i]   = 10'(ones);
    e_err[i]  = er;
    e_fv[i]   = 1'b1;
  endtask

  task automatic model_step(logic e, logic fs, logic r, logic b0, logic b2);
    bit s [2];
    if (r) begin
      m_cnt = 0;
      hq2 = '{1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
        e_word[i] = '0; e_wt[i] = '0; e_err[i] = 1'b0; e_fv[i] = 1'b0;
        clear_rec(i);
      end
      return;
    end
    s[0] = b0;
    s[1] = hq2[0];
    e_fv[0] = 1'b0;
    e_fv[1] = 1'b0;
    if (fs) begin
      clear_rec(0);
      clear_rec(1);
    end else if (e) begin
      if (m_cnt == 1023) begin
        close_frame(0);
        close_frame(1);
        clear_rec(0);
        clear_rec(1);
      end else begin
        for (int i = 0; i < 2; i++) begin
          rec[i][m_cnt]  = s[i];
          recv[i][m_cnt] = 1'b1;
        end
      end
    end
    if (e) begin
      hq2.push_back(b2);
      void'(hq2.pop_front());
    end
    if (fs)     m_cnt = 0;
    else if (e) m_cnt = (m_cnt + 1) % 1024;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic fs, input logic r, input logic b0, input logic b2);
    @(negedge clk_ext);
    en = e; frame_sync = fs; rst_ext = r; ser0 = b0; ser2 = b2;
    @(posedge clk_ext);
    model_step(e, fs, r, b0, b2);
    #1;
    chk("fv0",   32'(fv0),   32'(e_fv[0]));
    chk("word0", 32'(word0), 32'(e_word[0]));
    chk("wt0",   32'(wt0),   32'(e_wt[0]));
    chk("err0",  32'(err0),  32'(e_err[0]));
    chk("fv2",   32'(fv2),   32'(e_fv[1]));
    chk("word2", 32'(word2), 32'(e_word[1]));
    chk("wt2",   32'(wt2),   32'(e_wt[1]));
    chk("err2",  32'(err2),  32'(e_err[1]));
  endtask

  // Drives the pattern until dut0 publishes a frame (bounded). ser2 leads by
  // two enabled positions so the ALIGN_DLY=2 instance sees the same frame.
  task automatic run_frame(input logic [9:0] p, input int inv_at, input int gap_at,
                           input int gap_len, input int sync_at,
                           output int n, output int n_sync);
    int  gap = 0;
    bit  synced = 1'b0;
    logic e, fs, b0, b2;
    n = 0;
    n_sync = -1;
    do begin
      e = 1'b1;
      fs = 1'b0;
      if (m_cnt == gap_at && gap < gap_len) begin
        e = 1'b0;
        gap++;
      end
      if (!synced && e && m_cnt == sync_at) begin
        fs = 1'b1;
        synced = 1'b1;
      end
      b0 = pat_bit(m_cnt, p) ^ (m_cnt == inv_at);
      b2 = pat_bit(m_cnt + 2, p) ^ (((m_cnt + 2) % 1024) == inv_at);
      cyc(e, fs, 1'b0, b0, b2);
      n++;
      if (fs) n_sync = 0;
      else if (n_sync >= 0) n_sync++;
    end while (!fv0 && n < 3000);
    chk("frame_seen", 32'(fv0), 32'd1);
  endtask

  localparam logic [9:0] PAT = 10'b1100000011;

  initial begin
    int n, ns;
    logic [9:0] rword;
    bit mode;
    logic e, fs, r, b0, b2;

    // reset held three cycles
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_word0", 32'(word0), 32'd0);
    chk("rst_wt0",   32'(wt0),   32'd0);
    chk("rst_fv0",   32'(fv0),   32'd0);
    chk("rst_err0",  32'(err0),  32'd0);

    // clean frame
    run_frame(PAT, -1, -1, 0, -1, n, ns);
    chk("a_cycles", 32'(n), 32'd1024);
    chk("a_word",   32'(word0), 32'(PAT));
    chk("a_wt",     32'(wt0), 32'd771);
    chk("a_err",    32'(err0), 32'd0);

    // last slot-3 occurrence (cnt=1015) inverted
    run_frame(PAT, 1015, -1, 0, -1, n, ns);
    chk("b_cycles", 32'(n), 32'd1024);
    chk("b_word",   32'(word0), 32'(10'b1100001011));
    chk("b_wt",     32'(wt0), 32'd772);
    chk("b_err",    32'(err0), 32'd1);

    // 50-cycle en gap at cnt=300 stretches the frame
    run_frame(PAT, -1, 300, 50, -1, n, ns);
    chk("c_cycles", 32'(n), 32'd1074);
    chk("c_word",   32'(word0), 32'(PAT));
    chk("c_wt",     32'(wt0), 32'd771);

    // frame_sync at cnt=600 restarts the frame
    run_frame(PAT, -1, -1, 0, 600, n, ns);
    chk("d_cycles", 32'(n), 32'd1625);
    chk("d_after_sync", 32'(ns), 32'd1024);
    chk("d_word",   32'(word0), 32'(PAT));
    chk("d_err",    32'(err0), 32'd0);

    // reset at cnt=500 loses the partial frame
    n = 0;
    while (m_cnt != 500 && n < 2000) begin
      cyc(1'b1, 1'b0, 1'b0, pat_bit(m_cnt, PAT), pat_bit(m_cnt + 2, PAT));
      n++;
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("e_rst_word2", 32'(word2), 32'd0);
    chk("e_rst_wt2",   32'(wt2),   32'd0);
    chk("e_rst_err2",  32'(err2),  32'd0);
    run_frame(PAT, -1, -1, 0, -1, n, ns);
    chk("e_cycles", 32'(n), 32'd1024);
    chk("e_word2",  32'(word2), 32'(PAT));
    run_frame(PAT, -1, -1, 0, -1, n, ns);
    chk("e2_word2", 32'(word2), 32'(PAT));
    chk("e2_wt2",   32'(wt2), 32'd771);
    chk("e2_err2",  32'(err2), 32'd0);

    // randomized traffic
    for (int blk = 0; blk < 8; blk++) begin
      rword = 10'($urandom);
      mode  = 1'($urandom_range(0, 1));
      for (int j = 0; j < 1100; j++) begin
        e  = ($urandom_range(0, 9) != 0);
        fs = ($urandom_range(0, 1499) == 0);
        r  = ($urandom_range(0, 3999) == 0);
        b0 = mode ? pat_bit(m_cnt, rword)     : 1'($urandom_range(0, 1));
        b2 = mode ? pat_bit(m_cnt + 2, rword) : 1'($urandom_range(0, 1));
        cyc(e, fs, r, b0, b2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
